// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the instruction store and its byte-stream loader.
package instruction_memory_loader_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    StLoad,
    StRun
  } load_state_e;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Load stream, fetch port and status signals of the instruction memory loader.
interface instruction_memory_loader_if #(
  parameter int unsigned ADDRESS_SIZE = 6,
  parameter int unsigned N            = 64
);
  import instruction_memory_loader_pkg::*;

  logic                    load_valid;
  logic [7:0]              load_byte;
  logic                    load_last;
  logic                    load_ready;
  logic                    load_start;
  logic                    ins_write;
  logic                    load_done;
  logic [ADDRESS_SIZE:0]   prog_words;
  logic [N-1:0]            instr_addr;
  logic [DATA_WIDTH-1:0]   instruction;
  logic                    addr_fault;

  modport master (
    output load_valid, load_byte, load_last, load_start, instr_addr,
    input  load_ready, ins_write, load_done, prog_words, instruction, addr_fault
  );

  modport slave (
    input  load_valid, load_byte, load_last, load_start, instr_addr,
    output load_ready, ins_write, load_done, prog_words, instruction, addr_fault
  );

endinterface

// File: rtl/instruction_memory_loader_assembler.sv
// Packs little-endian bytes into 32-bit words; strobes word completion on lane 3 or last byte.
module load_word_assembler
  import instruction_memory_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [7:0]            byte_i,
  input  logic                  last_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  complete_o,
  output lane_idx_t             byte_idx_o
);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  lane_idx_t             idx_q, idx_d;

  // Merged view includes the byte being accepted this cycle, so a write can use it directly.
  always_comb begin
    word_o                        = shift_q;
    word_o[{idx_q, 3'b000} +: 8]  = byte_i;
    complete_o                    = accept_i & (last_i | (idx_q == 2'd3));
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (accept_i) begin
      if (complete_o) begin
        shift_d = '0;
        idx_d   = '0;
      end else begin
        shift_d = word_o;
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    idx_q   <= idx_d;
  end

  assign byte_idx_o = idx_q;

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction store with a byte-stream loader FSM and a zero-latency fetch path.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = 6,
  parameter int unsigned N            = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_memory_loader_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE-1:0] LastPtr = ADDRESS_SIZE'(Depth - 1);

  load_state_e               state_q;
  logic [ADDRESS_SIZE-1:0]   word_ptr_q;
  logic [ADDRESS_SIZE:0]     prog_words_q;
  logic                      ready_q;
  logic                      ins_write_q;
  logic                      done_q;
  logic [DATA_WIDTH-1:0]     mem_q [Depth];

  logic                      accept;
  logic                      asm_clear;
  logic                      word_wr;
  logic [DATA_WIDTH-1:0]     asm_word;
  lane_idx_t                 asm_idx;
  logic [ADDRESS_SIZE:0]     prog_words_d;

  assign accept       = bus.load_valid & ready_q;
  assign asm_clear    = rst | ((state_q == StRun) & bus.load_start);
  assign prog_words_d = (ADDRESS_SIZE + 1)'(word_ptr_q) + 1'b1;

  load_word_assembler u_asm (
    .clk        (clk),
    .clear_i    (asm_clear),
    .accept_i   (accept),
    .byte_i     (bus.load_byte),
    .last_i     (bus.load_last),
    .word_o     (asm_word),
    .complete_o (word_wr),
    .byte_idx_o (asm_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      word_ptr_q   <= '0;
      prog_words_q <= '0;
      ready_q      <= 1'b1;
      ins_write_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (word_wr) begin
            word_ptr_q   <= word_ptr_q + 1'b1;
            prog_words_q <= prog_words_d;
            // A full store forces RUN, so word_ptr never wraps onto loaded words.
            if (bus.load_last || (word_ptr_q == LastPtr)) begin
              state_q     <= StRun;
              ready_q     <= 1'b0;
              ins_write_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.load_start) begin
            state_q      <= StLoad;
            word_ptr_q   <= '0;
            prog_words_q <= '0;
            ready_q      <= 1'b1;
            ins_write_q  <= 1'b1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // Store is never cleared; prog_words alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && word_wr) begin
      mem_q[word_ptr_q] <= asm_word;
    end
  end

  logic [ADDRESS_SIZE-1:0] rd_idx;
  logic                    hi_nz;

  always_comb begin
    rd_idx          = bus.instr_addr[ADDRESS_SIZE-1:0];
    hi_nz           = |bus.instr_addr[N-1:ADDRESS_SIZE];
    bus.instruction = NOP;
    bus.addr_fault  = 1'b0;
    if (state_q == StRun) begin
      if (hi_nz || ((ADDRESS_SIZE + 1)'(rd_idx) >= prog_words_q)) begin
        bus.addr_fault = 1'b1;
      end else begin
        bus.instruction = mem_q[rd_idx];
      end
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.ins_write  = ins_write_q;
  assign bus.load_done  = done_q;
  assign bus.prog_words = prog_words_q;

  logic unused_idx;
  assign unused_idx = ^asm_idx;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: load, fetch, fault, full store, reset, reload.
module tb_instruction_memory_loader;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  instruction_memory_loader_if #(.ADDRESS_SIZE(6), .N(64)) bus ();

  instruction_memory_loader #(.ADDRESS_SIZE(6), .N(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.load_done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    bus.load_last  = last;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [63:0] addr,
                       input logic [31:0] exp_ins, input logic exp_fault);
    bus.instr_addr = addr;
    #1;
    chk({tag, "_ins"}, 64'(bus.instruction), 64'(exp_ins));
    chk({tag, "_flt"}, 64'(bus.addr_fault), 64'(exp_fault));
  endtask

  task automatic reload();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  logic [7:0] prog1 [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  logic [7:0] prog3 [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
  logic [7:0] prog5 [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    bus.load_valid = 1'b0;
    bus.load_byte  = '0;
    bus.load_last  = 1'b0;
    bus.load_start = 1'b0;
    bus.instr_addr = '0;
    step();
    do_reset();

    // Reset state
    chk("rst_pw",    64'(bus.prog_words), 64'd0);
    chk("rst_rdy",   64'(bus.load_ready), 64'd1);
    chk("rst_insw",  64'(bus.ins_write),  64'd1);
    chk("rst_done",  64'(bus.load_done),  64'd0);
    fetch("rst", 64'd0, Nop, 1'b0);

    // 1: basic load and fetch
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("s1_insw_pre", 64'(bus.ins_write), 64'd1);
      send_byte(prog1[i], i == 7);
    end
    chk("s1_pw",    64'(bus.prog_words), 64'd2);
    chk("s1_done",  64'(bus.load_done),  64'd1);
    chk("s1_insw",  64'(bus.ins_write),  64'd0);
    chk("s1_rdy",   64'(bus.load_ready), 64'd0);
    step();
    step();
    chk("s1_done_cnt", 64'(done_cnt), 64'd1);
    fetch("s1_a0", 64'd0, 32'h0010_0513, 1'b0);
    fetch("s1_a1", 64'd1, 32'h0020_0593, 1'b0);

    // 2: out-of-program fetches
    fetch("s2_a2",  64'd2,              Nop,          1'b1);
    fetch("s2_hi",  64'h1_0000_0000,    Nop,          1'b1);
    fetch("s2_a0",  64'd0,              32'h0010_0513, 1'b0);

    // 3: partial last word
    reload();
    for (int i = 0; i < 6; i++) send_byte(prog3[i], i == 5);
    chk("s3_pw",  64'(bus.prog_words), 64'd2);
    chk("s3_idx", 64'(dut.u_asm.idx_q), 64'd0);
    fetch("s3_w0", 64'd0, 32'h0403_0201, 1'b0);
    fetch("s3_w1", 64'd1, 32'h0000_BBAA, 1'b0);

    // 4: full store, with valid gaps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i % 7 == 3) step();
      if (i == 255) begin
        chk("s4_pw_pre",  64'(bus.prog_words), 64'd63);
        chk("s4_rdy_pre", 64'(bus.load_ready), 64'd1);
      end
      send_byte(8'(i), 1'b0);
    end
    chk("s4_rdy",  64'(bus.load_ready), 64'd0);
    chk("s4_insw", 64'(bus.ins_write),  64'd0);
    chk("s4_pw",   64'(bus.prog_words), 64'd64);
    send_byte(8'hFF, 1'b0);
    chk("s4_pw_257", 64'(bus.prog_words), 64'd64);
    fetch("s4_a63", 64'd63, 32'hFFFE_FDFC, 1'b0);
    fetch("s4_a0",  64'd0,  32'h0302_0100, 1'b0);

    // 5: reset mid-load; reset also wins over a simultaneous accept
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
    chk("s5_pw_mid", 64'(bus.prog_words), 64'd1);
    rst = 1'b1;
    send_byte(8'h77, 1'b1);
    rst = 1'b0;
    chk("s5_pw_rst",   64'(bus.prog_words), 64'd0);
    chk("s5_insw_rst", 64'(bus.ins_write),  64'd1);
    chk("s5_idx_rst",  64'(dut.u_asm.idx_q), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(prog5[i], i == 3);
    chk("s5_pw", 64'(bus.prog_words), 64'd1);
    fetch("s5_w0", 64'd0, 32'hDEAD_BEEF, 1'b0);
    fetch("s5_w1", 64'd1, Nop,           1'b1);

    // 6: reload from RUN; load_start is ignored while loading
    reload();
    chk("s6_insw", 64'(bus.ins_write),  64'd1);
    chk("s6_pw",   64'(bus.prog_words), 64'd0);
    fetch("s6_load", 64'd0, Nop, 1'b0);
    bus.load_start = 1'b1;
    send_byte(8'h6F, 1'b0);
    bus.load_start = 1'b0;
    chk("s6_idx", 64'(dut.u_asm.idx_q), 64'd1);
    send_byte(8'h00, 1'b1);
    chk("s6_pw1", 64'(bus.prog_words), 64'd1);
    fetch("s6_w0", 64'd0, 32'h0000_006F, 1'b0);
    fetch("s6_w1", 64'd1, Nop,           1'b1);

    // Single-byte program: last on lane 0 keeps the byte
    reload();
    send_byte(8'hA5, 1'b1);
    chk("s6_lane0_pw", 64'(bus.prog_words), 64'd1);
    fetch("s6_lane0", 64'd0, 32'h0000_00A5, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
